// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial receiver for 7-bit frames (start, 4 data bits LSB
// first, parity, stop). It reports the nibble, the parity bit, a parity error
// against the mode latched at the start bit, and a framing error on a low stop bit.
module parity_frame_rx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       trig,
    output logic [3:0] data,
    output logic       parity,
    output logic       valid,
    output logic       par_err,
    output logic       frm_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    bit_idx;
    logic [3:0]    shreg;
    logic          par_q;
    logic          mode_q;
    logic          armed;
    logic          rx_meta;
    logic          rx_s;
    logic [1:0]    rst_q;
    logic          run;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Reset-release synchronizer: the FSM stays frozen in IDLE for two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_q <= '0;
        end else begin
            rst_q <= {rst_q[0], 1'b1};
        end
    end

    assign run = rst_q[1];

    // Receive FSM: mid-bit sampling, data shifting, and result registers.
    // The armed flag blocks a low stop bit (or a line held low from reset) from
    // being taken as a new start bit until the line has been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            mode_q  <= 1'b0;
            armed   <= 1'b0;
            data    <= '0;
            parity  <= 1'b0;
            valid   <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (run) begin
                case (state)
                    S_IDLE: begin
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state  <= S_START;
                            cnt    <= '0;
                            mode_q <= trig;
                        end
                    end
                    S_START: begin
                        if (cnt == HALF_LAST) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_DATA: begin
                        if (cnt == FULL_LAST) begin
                            cnt     <= '0;
                            shreg   <= {rx_s, shreg[3:1]};
                            bit_idx <= bit_idx + 2'd1;
                            if (bit_idx == 2'd3) begin
                                state <= S_PAR;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_PAR: begin
                        if (cnt == FULL_LAST) begin
                            cnt   <= '0;
                            par_q <= rx_s;
                            state <= S_STOP;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_STOP: begin
                        if (cnt == FULL_LAST) begin
                            cnt     <= '0;
                            data    <= shreg;
                            parity  <= par_q;
                            par_err <= (^shreg) ^ par_q ^ mode_q;
                            frm_err <= ~rx_s;
                            valid   <= 1'b1;
                            armed   <= rx_s;
                            state   <= S_IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Busy whenever a frame is in progress.
    always_comb begin
        busy = (state != S_IDLE);
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: table-driven frame vectors plus directed sequences for
// glitch rejection, low stop bit hold-off, back-to-back frames and mid-frame reset.
module tb_parity_frame_rx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       trig;
    logic [3:0] data;
    logic       parity;
    logic       valid;
    logic       par_err;
    logic       frm_err;
    logic       busy;

    always #5 clk = ~clk;

    parity_frame_rx #(.CLKS_PER_BIT(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .trig    (trig),
        .data    (data),
        .parity  (parity),
        .valid   (valid),
        .par_err (par_err),
        .frm_err (frm_err),
        .busy    (busy)
    );

    typedef struct {
        logic       trig;
        logic       flip;
        logic [3:0] d;
        logic       p;
        logic       stop;
        logic [3:0] exp_d;
        logic       exp_p;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    localparam int NV = 9;
    vec_t vt [NV];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int vcount    = 0;
    int busy_hits = 0;
    int last_vcyc = 0;
    int prev_vcyc = 0;
    logic last_pe = 1'b0;
    logic prev_pe = 1'b0;

    // Output monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid === 1'b1) begin
            vcount    = vcount + 1;
            prev_vcyc = last_vcyc;
            last_vcyc = cyc;
            prev_pe   = last_pe;
            last_pe   = par_err;
        end
        if (busy === 1'b1) begin
            busy_hits = busy_hits + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one frame; bit 0 is the start bit. Leaves rx at the stop value.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic stop, input logic flip);
        logic [6:0] bits;
        bits = {stop, p, d, 1'b0};
        for (int i = 0; i < 7; i++) begin
            rx = bits[i];
            if (i == 1 && flip) trig = ~trig;
            repeat (N) @(negedge clk);
        end
    endtask

    initial begin
        int v0;
        int b0;
        logic [3:0] snap_d;
        logic snap_p, snap_pe, snap_fe;

        //            trig  flip  d        p     stop  exp_d    exp_p exp_pe exp_fe
        vt[0] = '{1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 4'b1011, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0};
        vt[2] = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b0, 4'b0110, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b1, 4'b0101, 1'b1, 1'b1, 4'b0101, 1'b1, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b0, 4'b1100, 1'b1, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b1};
        vt[8] = '{1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        rx    = 1'b1;
        trig  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset data",    32'(data),    32'd0);
        check("reset parity",  32'(parity),  32'd0);
        check("reset valid",   32'(valid),   32'd0);
        check("reset par_err", 32'(par_err), 32'd0);
        check("reset frm_err", 32'(frm_err), 32'd0);
        check("reset busy",    32'(busy),    32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Table-driven frames.
        for (int k = 0; k < NV; k++) begin
            trig = vt[k].trig;
            v0   = vcount;
            send_frame(vt[k].d, vt[k].p, vt[k].stop, vt[k].flip);
            rx = 1'b1;
            repeat (10) @(negedge clk);
            check($sformatf("vec%0d valid_cycles", k), 32'(vcount - v0), 32'd1);
            check($sformatf("vec%0d data", k),    32'(data),    32'(vt[k].exp_d));
            check($sformatf("vec%0d parity", k),  32'(parity),  32'(vt[k].exp_p));
            check($sformatf("vec%0d par_err", k), 32'(par_err), 32'(vt[k].exp_pe));
            check($sformatf("vec%0d frm_err", k), 32'(frm_err), 32'(vt[k].exp_fe));
        end

        // One-cycle glitch: busy for exactly two cycles, no valid, outputs held.
        snap_d = data; snap_p = parity; snap_pe = par_err; snap_fe = frm_err;
        #1;
        v0 = vcount;
        b0 = busy_hits;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("glitch busy_cycles", 32'(busy_hits - b0), 32'd2);
        check("glitch busy_end",    32'(busy),           32'd0);
        check("glitch no_valid",    32'(vcount - v0),    32'd0);
        check("glitch data_hold",   32'(data),           32'(snap_d));
        check("glitch flags_hold",  32'({parity, par_err, frm_err}), 32'({snap_p, snap_pe, snap_fe}));

        // Low stop bit with the line held low afterwards.
        trig = 1'b0;
        v0   = vcount;
        send_frame(4'b0110, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        b0 = busy_hits;
        check("stoplow valid_cycles", 32'(vcount - v0), 32'd1);
        check("stoplow data",    32'(data),    32'h6);
        check("stoplow parity",  32'(parity),  32'd0);
        check("stoplow par_err", 32'(par_err), 32'd0);
        check("stoplow frm_err", 32'(frm_err), 32'd1);
        repeat (10) @(negedge clk);
        #1;
        check("stoplow no_restart", 32'(busy_hits - b0), 32'd0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        v0 = vcount;
        send_frame(4'b1011, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("after_stoplow valid_cycles", 32'(vcount - v0), 32'd1);
        check("after_stoplow data",         32'(data),        32'hB);
        check("after_stoplow frm_err",      32'(frm_err),     32'd0);

        // Back-to-back frames.
        trig = 1'b0;
        v0   = vcount;
        send_frame(4'b0001, 1'b1, 1'b1, 1'b0);
        send_frame(4'b1111, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("b2b valid_cycles", 32'(vcount - v0),          32'd2);
        check("b2b spacing",      32'(last_vcyc - prev_vcyc), 32'd28);
        check("b2b first_pe",     32'(prev_pe),               32'd0);
        check("b2b second_pe",    32'(last_pe),               32'd0);
        check("b2b data",         32'(data),                  32'hF);

        // Reset during data bit d2 of a 4'b1011 frame.
        v0 = vcount;
        rx = 1'b0; repeat (N) @(negedge clk);
        rx = 1'b1; repeat (N) @(negedge clk);
        rx = 1'b1; repeat (N) @(negedge clk);
        rx = 1'b0; repeat (N / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst data",    32'(data),    32'd0);
        check("midrst parity",  32'(parity),  32'd0);
        check("midrst par_err", 32'(par_err), 32'd0);
        check("midrst frm_err", 32'(frm_err), 32'd0);
        check("midrst valid",   32'(valid),   32'd0);
        check("midrst busy",    32'(busy),    32'd0);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst no_valid", 32'(vcount - v0), 32'd0);
        check("midrst idle",     32'(busy),        32'd0);
        v0 = vcount;
        send_frame(4'b1000, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("postrst valid_cycles", 32'(vcount - v0), 32'd1);
        check("postrst data",         32'(data),        32'h8);
        check("postrst par_err",      32'(par_err),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
